// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan byte decoder: prefix FSM, modifier tracking, US ASCII translation
// and a first-word-fall-through event FIFO with valid/ready drain.
module ps2_key_decoder #(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_scan,
  input  logic [7:0] scan_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic [7:0] key_ascii,
  output logic       key_release,
  output logic       key_extended,
  output logic       shift_held,
  output logic       caps_on,
  output logic       overflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] ascii;
    logic       is_break;
    logic       is_ext;
  } key_event_t;

  typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0, S_SKIP} state_t;

  state_t     state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic       ev_push, ev_break, ev_ext;
  logic       lshift_q, rshift_q, caps_q, caps_held_q;
  logic [7:0] ev_ascii;

  key_event_t                  mem [DEPTH];
  logic [DEPTH_LOG2-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]               count_q;
  logic                        full_c, pop_c, push_ok_c;
  key_event_t                  head_c;

  // US layout; letters flip case on shift XOR caps, everything else follows shift only
  function automatic logic [7:0] to_ascii(input logic [7:0] code, input logic shift,
                                          input logic caps);
    logic [7:0] lo;
    logic [7:0] hi;
    logic       letter;
    lo = 8'h00;
    hi = 8'h00;
    letter = 1'b0;
    case (code)
      8'h1C: begin lo = "a"; letter = 1'b1; end
      8'h32: begin lo = "b"; letter = 1'b1; end
      8'h21: begin lo = "c"; letter = 1'b1; end
      8'h23: begin lo = "d"; letter = 1'b1; end
      8'h24: begin lo = "e"; letter = 1'b1; end
      8'h2B: begin lo = "f"; letter = 1'b1; end
      8'h34: begin lo = "g"; letter = 1'b1; end
      8'h33: begin lo = "h"; letter = 1'b1; end
      8'h43: begin lo = "i"; letter = 1'b1; end
      8'h3B: begin lo = "j"; letter = 1'b1; end
      8'h42: begin lo = "k"; letter = 1'b1; end
      8'h4B: begin lo = "l"; letter = 1'b1; end
      8'h3A: begin lo = "m"; letter = 1'b1; end
      8'h31: begin lo = "n"; letter = 1'b1; end
      8'h44: begin lo = "o"; letter = 1'b1; end
      8'h4D: begin lo = "p"; letter = 1'b1; end
      8'h15: begin lo = "q"; letter = 1'b1; end
      8'h2D: begin lo = "r"; letter = 1'b1; end
      8'h1B: begin lo = "s"; letter = 1'b1; end
      8'h2C: begin lo = "t"; letter = 1'b1; end
      8'h3C: begin lo = "u"; letter = 1'b1; end
      8'h2A: begin lo = "v"; letter = 1'b1; end
      8'h1D: begin lo = "w"; letter = 1'b1; end
      8'h22: begin lo = "x"; letter = 1'b1; end
      8'h35: begin lo = "y"; letter = 1'b1; end
      8'h1A: begin lo = "z"; letter = 1'b1; end
      8'h16: begin lo = "1"; hi = "!"; end
      8'h1E: begin lo = "2"; hi = "@"; end
      8'h26: begin lo = "3"; hi = "#"; end
      8'h25: begin lo = "4"; hi = "$"; end
      8'h2E: begin lo = "5"; hi = "%"; end
      8'h36: begin lo = "6"; hi = "^"; end
      8'h3D: begin lo = "7"; hi = "&"; end
      8'h3E: begin lo = "8"; hi = "*"; end
      8'h46: begin lo = "9"; hi = "("; end
      8'h45: begin lo = "0"; hi = ")"; end
      8'h4E: begin lo = "-"; hi = "_"; end
      8'h55: begin lo = "="; hi = "+"; end
      8'h54: begin lo = "["; hi = "{"; end
      8'h5B: begin lo = "]"; hi = "}"; end
      8'h4C: begin lo = ";"; hi = ":"; end
      8'h52: begin lo = "'"; hi = "\""; end
      8'h41: begin lo = ","; hi = "<"; end
      8'h49: begin lo = "."; hi = ">"; end
      8'h4A: begin lo = "/"; hi = "?"; end
      8'h5D: begin lo = "\\"; hi = "|"; end
      8'h0E: begin lo = 8'h60; hi = "~"; end
      8'h29: begin lo = 8'h20; hi = 8'h20; end
      8'h5A: begin lo = 8'h0D; hi = 8'h0D; end
      8'h66: begin lo = 8'h08; hi = 8'h08; end
      8'h0D: begin lo = 8'h09; hi = 8'h09; end
      8'h76: begin lo = 8'h1B; hi = 8'h1B; end
      default: begin lo = 8'h00; hi = 8'h00; end
    endcase
    if (letter) return (shift ^ caps) ? (lo - 8'h20) : lo;
    return shift ? hi : lo;
  endfunction

  // Prefix FSM: next state and event strobe
  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    ev_push  = 1'b0;
    ev_break = 1'b0;
    ev_ext   = 1'b0;
    if (valid_scan) begin
      case (state_q)
        S_IDLE: begin
          case (scan_code)
            8'hE0: state_d = S_E0;
            8'hF0: state_d = S_F0;
            8'hE1: begin
              state_d = S_SKIP;
              skip_d  = 3'd7;
            end
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: state_d = S_IDLE;
            default: ev_push = 1'b1;
          endcase
        end
        S_E0: begin
          if (scan_code == 8'hF0) begin
            state_d = S_E0F0;
          end else begin
            state_d = S_IDLE;
            ev_ext  = 1'b1;
            ev_push = (scan_code != 8'h12) && (scan_code != 8'h59);
          end
        end
        S_F0: begin
          state_d  = S_IDLE;
          ev_push  = 1'b1;
          ev_break = 1'b1;
        end
        S_E0F0: begin
          state_d  = S_IDLE;
          ev_ext   = 1'b1;
          ev_break = 1'b1;
          ev_push  = (scan_code != 8'h12) && (scan_code != 8'h59);
        end
        S_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      skip_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  // Modifier tracking; a held caps key ignores typematic repeats
  always_ff @(posedge clk) begin
    if (reset) begin
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
    end else if (ev_push && !ev_ext) begin
      case (scan_code)
        8'h12: lshift_q <= !ev_break;
        8'h59: rshift_q <= !ev_break;
        8'h58: begin
          if (ev_break) begin
            caps_held_q <= 1'b0;
          end else begin
            if (!caps_held_q) caps_q <= !caps_q;
            caps_held_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign shift_held = lshift_q | rshift_q;
  assign caps_on    = caps_q;
  assign ev_ascii   = ev_ext ? 8'h00 : to_ascii(scan_code, shift_held, caps_q);

  assign full_c    = (count_q == CW'(DEPTH));
  assign pop_c     = key_valid && key_ready;
  assign push_ok_c = ev_push && (!full_c || pop_c);

  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr_q] <= '{code: scan_code, ascii: ev_ascii,
                                       is_break: ev_break, is_ext: ev_ext};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (pop_c)     rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      if (ev_push && !push_ok_c) overflow <= 1'b1;
      if (push_ok_c && !pop_c)      count_q <= count_q + CW'(1);
      else if (!push_ok_c && pop_c) count_q <= count_q - CW'(1);
    end
  end

  // Head is forced to zero while empty so idle outputs match the reset state
  assign head_c       = mem[rd_ptr_q];
  assign key_valid    = (count_q != '0);
  assign key_code     = key_valid ? head_c.code     : 8'h00;
  assign key_ascii    = key_valid ? head_c.ascii    : 8'h00;
  assign key_release  = key_valid ? head_c.is_break : 1'b0;
  assign key_extended = key_valid ? head_c.is_ext   : 1'b0;

endmodule
